// File: rtl/register_file_wb_port.sv
// Architectural RV64 integer register file: write-back commit handshake,
// bypassed decode read ports, busy scoreboard and a full register view.
module register_file_wb_port #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     NUM_REGS = 32,
    parameter logic [XLEN-1:0] SP_INIT  = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_module_enable,
    input  logic            register_write_enable,
    input  logic [4:0]      register_write_addr,
    input  logic [XLEN-1:0] register_write_data,
    output logic            wb_write_complete,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            sb_set_valid,
    input  logic [4:0]      sb_set_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [XLEN-1:0] register [NUM_REGS]
);

    localparam int unsigned SP_IDX = 2;

    typedef enum logic {IDLE, DONE} state_t;

    state_t              state, next_state;
    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                commit;
    logic                commit_wr;

    // A request is accepted only once per handshake; x0 writes complete but change nothing.
    assign commit    = (state == IDLE) && wb_module_enable && register_write_enable;
    assign commit_wr = commit && (register_write_addr != 5'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (commit) next_state = DONE;
            DONE: if (!wb_module_enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            wb_write_complete <= 1'b0;
        end else begin
            state             <= next_state;
            wb_write_complete <= (next_state == DONE);
        end
    end

    // NOTE: this array is architectural state with a defined reset value (x2 = SP_INIT),
    // so unlike a plain storage RAM it must be reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (commit_wr) begin
            regs[register_write_addr] <= register_write_data;
        end
    end

    // Set is applied after clear so a newer in-flight producer keeps the register busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (commit_wr) busy[register_write_addr] <= 1'b0;
            if (sb_set_valid && (sb_set_addr != 5'd0)) busy[sb_set_addr] <= 1'b1;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (commit_wr && (register_write_addr == rs1_addr)) rs1_data = register_write_data;
        if (commit_wr && (register_write_addr == rs2_addr)) rs2_data = register_write_data;
    end

    assign rs1_busy = (rs1_addr != 5'd0) && busy[rs1_addr];
    assign rs2_busy = (rs2_addr != 5'd0) && busy[rs2_addr];

    assign register = regs;

endmodule
